// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: 2-flop sync, clock deglitch filter, 11-bit frame deframer.
// Optional inter-edge frame timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data,
   output logic       valid,
   output logic       error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;
   localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

   generate
      if (FILTER_LEN < 2 || FILTER_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
         $error("ps2_rx: FILTER_LEN must be 2..255 and TIMEOUT_CYCLES at least 2");
      end
   endgenerate

   logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic       filt_clk_q, filt_clk_d;
   logic [7:0] filt_cnt_q, filt_cnt_d;
   logic       fall;
   logic [1:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       error_q, error_d;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      if (fall || state_q == S_IDLE) to_cnt_d = '0;
      else                           to_cnt_d = to_cnt_q + TO_W'(1);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_d;
   end
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Filtered clock only moves after FILTER_LEN consecutive differing samples.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = 8'd0;
      fall       = 1'b0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            filt_clk_d = clk_s2_q;
            fall       = filt_clk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      if (fall) begin
         case (state_q)
            S_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
            S_STOP: begin
               if (dat_s2_q && (^shift_q ^ par_q)) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
`ifdef PS2_RX_TIMEOUT_EN
      else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
         error_d   = 1'b1;
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
      end
`endif
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         filt_clk_q <= 1'b1;
         filt_cnt_q <= 8'd0;
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'd0;
         par_q      <= 1'b0;
         data_q     <= 8'd0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         filt_clk_q <= filt_clk_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         error_q    <= error_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;
   assign error = error_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: directed frames push expected outcomes, a monitor pops on strobes.
module tb_ps2_rx;
   localparam int FL = 8;
   localparam int TO = 1000;
   localparam int H  = 40;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       error;

   ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .nreset(nreset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data(data), .valid(valid), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [7:0] d;
   } exp_t;

   exp_t     q[$];
   int       checks = 0;
   int       failures = 0;
   logic     prev_strobe = 1'b0;
   time      err_time = 0;
   time      fall_time = 0;

   task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!nreset) begin
            prev_strobe = 1'b0;
         end else begin
            if (valid || error) begin
               chk_eq("valid_error_exclusive", {31'd0, valid & error}, 32'd0);
               chk_eq("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
               if (q.size() == 0) begin
                  chk_eq("unexpected_strobe", {23'd0, error, data}, 32'hFFFF);
               end else begin
                  e = q.pop_front();
                  chk_eq("strobe_kind_is_error", {31'd0, error}, {31'd0, e.is_err});
                  chk_eq("data", {24'd0, data}, {24'd0, e.d});
                  if (error) err_time = $time;
               end
            end
            prev_strobe = valid | error;
         end
      end
   end

   task automatic send_bits(input logic [7:0] d, input logic par, input logic stp,
                            input int glitch_bit, input int nbits);
      logic [10:0] f;
      f = {stp, par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         if (i == glitch_bit) begin
            repeat (H/2) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (H/2 - 3) @(posedge clk);
         end else begin
            repeat (H) @(posedge clk);
         end
         ps2_clk = 1'b0;
         fall_time = $time;
         repeat (H) @(posedge clk);
         ps2_clk = 1'b1;
      end
      repeat (H) @(posedge clk);
      ps2_data = 1'b1;
   endtask

   task automatic frame(input logic [7:0] d, input logic par, input logic stp,
                        input int glitch_bit, input logic exp_err, input logic [7:0] exp_d);
      q.push_back({exp_err, exp_d});
      send_bits(d, par, stp, glitch_bit, 11);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 3000 && q.size() != 0; i++) @(posedge clk);
      chk_eq(nm, q.size(), 32'd0);
   endtask

   task automatic idle_glitch();
      repeat (20) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clk);
   endtask

   initial begin : stimulus
      repeat (5) @(posedge clk);
      #1;
      chk_eq("reset_data", {24'd0, data}, 32'd0);
      chk_eq("reset_valid", {31'd0, valid}, 32'd0);
      chk_eq("reset_error", {31'd0, error}, 32'd0);
      nreset = 1'b1;
      repeat (50) @(posedge clk);

      idle_glitch();
      frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, 8'h1C);
      frame(8'hE0, 1'b0, 1'b1, -1, 1'b0, 8'hE0);
      frame(8'h75, 1'b0, 1'b1, -1, 1'b0, 8'h75);
      frame(8'h1C, 1'b1, 1'b1, -1, 1'b1, 8'h75);
      frame(8'hF0, 1'b1, 1'b1, -1, 1'b0, 8'hF0);
      frame(8'h1C, 1'b0, 1'b0, -1, 1'b1, 8'hF0);
      frame(8'hE0, 1'b0, 1'b1, -1, 1'b0, 8'hE0);
      idle_glitch();
      frame(8'h29, 1'b0, 1'b1, 3, 1'b0, 8'h29);
      frame(8'h29, 1'b0, 1'b1, 9, 1'b0, 8'h29);
      drain("drain_main");

      // Clock line held low while idle with data high: a single ignored fall.
      ps2_clk = 1'b0;
      repeat (500) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (100) @(posedge clk);

      send_bits(8'h55, 1'b0, 1'b1, -1, 4);
      #3 nreset = 1'b0;
      #1;
      chk_eq("midreset_data", {24'd0, data}, 32'd0);
      chk_eq("midreset_valid", {31'd0, valid}, 32'd0);
      chk_eq("midreset_error", {31'd0, error}, 32'd0);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      nreset = 1'b1;
      repeat (1500) @(posedge clk);
      frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, 8'h1C);
      drain("drain_after_reset");

`ifdef PS2_RX_TIMEOUT_EN
      q.push_back({1'b1, 8'h1C});
      send_bits(8'h1C, 1'b0, 1'b1, -1, 5);
      ps2_data = 1'b1;
      drain("drain_timeout");
      chk_eq("timeout_latency_in_window",
             {31'd0, ((err_time - fall_time) / 10 >= 1000) && ((err_time - fall_time) / 10 <= 1025)},
             32'd1);
      frame(8'h1C, 1'b0, 1'b1, -1, 1'b0, 8'h1C);
      drain("drain_after_timeout");
`endif

      repeat (200) @(posedge clk);
      chk_eq("final_queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 device-to-host serial receiver.
- Sits directly upstream of the keyboard matrix block and supplies its byte stream.
- Synchronises and deglitches the PS/2 clock and data lines, then deframes 11-bit frames: start, 8 data LSB first, odd parity, stop.
- Emits each good byte with a one-cycle valid strobe, and flags bad frames with a one-cycle error strobe.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised ps2_clk samples required before the filtered clock changes; legal range 2..255.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between falling edges inside a frame (~1 ms at 50 MHz); used only when PS2_RX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- data  out  8  last correctly received byte.
- valid  out  1  one-cycle strobe: data holds a new byte.
- error  out  1  one-cycle strobe: frame rejected.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (nreset); asserting it forces every register immediately.
  - Reset values: data=0x00, valid=0, error=0, state=IDLE, bit counter=0, shift register=0.
  - Synchroniser flops and filtered clock reset to 1; filter counter and timeout counter reset to 0.
  - Reset mid-frame discards the partial frame; no strobe is produced.
- Input conditioning:
  - Two-flop synchroniser on each of ps2_clk and ps2_data.
  - Filter: the counter increments while the synchronised clock differs from the filtered clock and clears when they match. When the counter reaches FILTER_LEN-1, the filtered clock takes the new value and the counter clears.
- Sample event: single-cycle "fall" when the filtered clock goes 1->0. ps2_data (synchronised) is sampled in that same cycle.
- States: IDLE, DATA, PARITY, STOP. Transitions occur only on fall, except timeout.
  - IDLE: sampled bit 0 -> DATA with bit counter=0. Sampled bit 1 -> stay in IDLE silently, no error.
  - DATA: shift right, sampled bit into bit 7; increment counter. After the 8th bit -> PARITY.
  - PARITY: latch parity bit -> STOP.
  - STOP: the frame is good when the stop bit is 1 AND the XOR of the 8 data bits and the parity bit is 1.
    - Good frame: data <= shift register, valid=1 for one cycle.
    - Bad frame: error=1 for one cycle, data unchanged.
    - Either way -> IDLE.
- Latency: valid/error assert in the cycle after the stop-bit fall event. Measured from the stop-bit pin falling edge, that is 2 (sync) + FILTER_LEN + 1 clk cycles.
- valid and error are never high together and never high for more than one cycle.
- data is stable between valid strobes. The downstream block must latch on valid.
- Back-to-back frames: no minimum gap beyond the PS/2 line timing. IDLE accepts a start bit on the first fall after STOP.
- Line held low indefinitely in IDLE: no event after the first fall, no error.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on every fall and increments each cycle while state != IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no fall in that cycle: error=1 for one cycle, state -> IDLE, bit counter=0, data unchanged.
  - If a fall and the timeout coincide in the same cycle, the fall wins and the frame continues.
- Not defined: no counter exists, and a truncated frame stays pending until further falls complete it.

Test Plan:
- Clean frame, 0x1C with parity 0 and stop 1, ~12 kHz PS/2 clock -> exactly one valid pulse; data=0x1C; error never high.
- Two frames, 0xE0 (parity 0) then 0x75 (parity 0), back to back -> two valid pulses carrying 0xE0 and 0x75 in order.
- Parity fault: frame 0x1C with parity bit 1 -> one error pulse, no valid, data keeps its previous value. A following good 0xF0 frame (parity 1) -> valid, data=0xF0.
- Framing fault: stop bit 0 on frame 0x1C -> one error pulse; state returns to IDLE; the next good frame is received.
- Glitch rejection, FILTER_LEN=8: 3-cycle low pulses on ps2_clk while idle and mid-frame -> no extra bits shifted; 0x29 is still received intact.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=1000:
  - Start plus 4 bits, then clock held high -> error pulse 1000 cycles after the last fall; a subsequent 0x1C frame gives valid, data=0x1C.
  - nreset asserted mid-frame -> outputs zero immediately, no strobe afterwards.
